// File: rtl/inst_dispatch_ctrl.sv
// rtl/inst_dispatch_ctrl.sv - instruction decoder/dispatcher with per-channel load guards
module inst_dispatch_ctrl #(
  parameter int INST_LEN = 220,
  parameter int NUM_LD   = 3,
  parameter int CMP_LEN  = 200,
  parameter int LD_LEN   = 96,
  parameter int GUARD    = 2,
  parameter int CNT_LEN  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [INST_LEN-1:0] inst,
  input  logic                inst_empty,
  output logic                inst_req,
  input  logic                cmp_ready,
  output logic                cmp_conf,
  output logic [CMP_LEN-1:0]  cmp_payload,
  input  logic [NUM_LD-1:0]   ld_idle,
  output logic [NUM_LD-1:0]   ld_conf,
  output logic [LD_LEN-1:0]   ld_payload,
  output logic [3:0]          ld_sel,
  output logic                err_illegal,
  output logic [CNT_LEN-1:0]  issue_cnt,
  output logic [CNT_LEN-1:0]  stall_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ISSUE, S_HOLD} state_t;

  state_t                 state, state_nx;
  logic [INST_LEN-1:0]    inst_r;
  logic [NUM_LD-1:0][3:0] guard;
  logic [NUM_LD-1:0]      busy, dep, ld_hit;
  logic [3:0]             typ, ld_ch;
  logic                   is_cmp, is_ld, is_sync, can_issue;
  logic                   unused_inst;

  assign typ         = inst_r[3:0];
  assign ld_ch       = typ - 4'd1;
  assign dep         = inst_r[INST_LEN-1 -: NUM_LD];
  assign is_cmp      = (typ == 4'd0);
  assign is_sync     = (typ == 4'hF);
  assign is_ld       = !is_cmp && (typ <= 4'(NUM_LD));
  assign unused_inst = ^inst_r;

  always_comb begin
    busy   = '0;
    ld_hit = '0;
    for (int c = 0; c < NUM_LD; c++) begin
      busy[c]   = ~ld_idle[c] | (guard[c] != 4'd0);
      ld_hit[c] = is_ld && (ld_ch == 4'(c));
    end
  end

  // Loads only look at their own channel; compute waits on its dep mask; sync drains everything.
  always_comb begin
    can_issue = 1'b1;
    if (is_cmp)       can_issue = cmp_ready & ~|(dep & busy);
    else if (is_ld)   can_issue = ~|(ld_hit & busy);
    else if (is_sync) can_issue = cmp_ready & ~|busy;
  end

  always_comb begin
    state_nx = state;
    inst_req = 1'b0;
    cmp_conf = 1'b0;
    ld_conf  = '0;
    case (state)
      S_IDLE:  if (!inst_empty) state_nx = S_WAIT;
      S_WAIT:  if (can_issue) state_nx = S_ISSUE;
      S_ISSUE: begin
        inst_req = 1'b1;
        cmp_conf = is_cmp;
        ld_conf  = ld_hit;
        state_nx = S_HOLD;
      end
      S_HOLD:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      inst_r      <= '0;
      guard       <= '0;
      cmp_payload <= '0;
      ld_payload  <= '0;
      ld_sel      <= '0;
      err_illegal <= 1'b0;
      issue_cnt   <= '0;
      stall_cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == S_IDLE && !inst_empty) inst_r <= inst;
      // Payloads land on the WAIT->ISSUE edge so they are valid alongside the conf pulse.
      if (state == S_WAIT) begin
        if (can_issue) begin
          if (is_cmp) cmp_payload <= inst_r[4 +: CMP_LEN];
          if (is_ld) begin
            ld_payload <= inst_r[4 +: LD_LEN];
            ld_sel     <= ld_ch;
          end
        end else if (~&stall_cnt) begin
          stall_cnt <= stall_cnt + CNT_LEN'(1);
        end
      end
      if (state == S_ISSUE) begin
        if (~&issue_cnt) issue_cnt <= issue_cnt + CNT_LEN'(1);
        if (!is_cmp && !is_ld && !is_sync) err_illegal <= 1'b1;
      end
      for (int c = 0; c < NUM_LD; c++) begin
        if (ld_conf[c])              guard[c] <= 4'(GUARD);
        else if (guard[c] != 4'd0)   guard[c] <= guard[c] - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_inst_dispatch_ctrl.sv
// tb/tb_inst_dispatch_ctrl.sv - directed and randomized checks of inst_dispatch_ctrl against a timestamp model
module tb_inst_dispatch_ctrl;

  localparam int INST_LEN = 220;
  localparam int NUM_LD   = 3;
  localparam int CMP_LEN  = 200;
  localparam int LD_LEN   = 96;
  localparam int GUARD    = 2;
  localparam int CNT_LEN  = 32;
  localparam int NCYC     = 4000;
  localparam int NI       = 200;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [INST_LEN-1:0] inst = '0;
  logic                inst_empty = 1'b1;
  logic                inst_req;
  logic                cmp_ready = 1'b0;
  logic                cmp_conf;
  logic [CMP_LEN-1:0]  cmp_payload;
  logic [NUM_LD-1:0]   ld_idle = '1;
  logic [NUM_LD-1:0]   ld_conf;
  logic [LD_LEN-1:0]   ld_payload;
  logic [3:0]          ld_sel;
  logic                err_illegal;
  logic [CNT_LEN-1:0]  issue_cnt;
  logic [CNT_LEN-1:0]  stall_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  logic [INST_LEN-1:0] words   [NI];
  int                  avail   [NI];
  int                  typ_arr [NI];
  logic [NUM_LD-1:0]   dep_arr [NI];
  logic [NUM_LD-1:0]   idle_arr [NCYC];
  bit                  rdy_arr  [NCYC];
  bit                  junk_arr [NCYC];
  bit                  e_req    [NCYC];
  bit                  e_cmp    [NCYC];
  logic [NUM_LD-1:0]   e_ld     [NCYC];
  bit                  e_stall  [NCYC];
  bit                  e_ill    [NCYC];
  int                  e_idx    [NCYC];
  int                  last_ld  [NUM_LD];

  always #5 clk = ~clk;

  inst_dispatch_ctrl #(
    .INST_LEN(INST_LEN), .NUM_LD(NUM_LD), .CMP_LEN(CMP_LEN),
    .LD_LEN(LD_LEN), .GUARD(GUARD), .CNT_LEN(CNT_LEN)
  ) dut (
    .clk(clk), .rst_n(rst_n), .inst(inst), .inst_empty(inst_empty), .inst_req(inst_req),
    .cmp_ready(cmp_ready), .cmp_conf(cmp_conf), .cmp_payload(cmp_payload),
    .ld_idle(ld_idle), .ld_conf(ld_conf), .ld_payload(ld_payload), .ld_sel(ld_sel),
    .err_illegal(err_illegal), .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
  );

  function automatic logic [INST_LEN-1:0] mk_word(input logic [3:0] t, input logic [NUM_LD-1:0] d);
    logic [223:0] w;
    w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    w[3:0] = t;
    w[INST_LEN-1 -: NUM_LD] = d;
    return w[INST_LEN-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    inst_empty = 1'b1;
    cmp_ready = 1'b0;
    ld_idle = '1;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  // Model: a channel is busy when its engine is not idle or it was issued 1..GUARD cycles ago.
  function automatic bit chan_busy(int ch, int c);
    return !idle_arr[c][ch] || ((c - last_ld[ch]) >= 1 && (c - last_ld[ch]) <= GUARD);
  endfunction

  function automatic bit issue_ok(int k, int c);
    int t = typ_arr[k];
    bit any = 1'b0;
    bit any_dep = 1'b0;
    for (int ch = 0; ch < NUM_LD; ch++) begin
      if (chan_busy(ch, c)) begin
        any = 1'b1;
        if (dep_arr[k][ch]) any_dep = 1'b1;
      end
    end
    if (t == 0) return rdy_arr[c] && !any_dep;
    if (t >= 1 && t <= NUM_LD) return !chan_busy(t - 1, c);
    if (t == 15) return rdy_arr[c] && !any;
    return 1'b1;
  endfunction

  // Issue timestamps: a word is seen at max(arrival, prev issue + 2), waited on from the
  // following cycle, and issued the cycle after its condition first holds.
  task automatic build_schedule(output int end_cyc);
    int a, prev, lc, c, iss, r, t;
    for (int i = 0; i < NCYC; i++) begin
      for (int b = 0; b < NUM_LD; b++) idle_arr[i][b] = ($urandom_range(0, 9) < 7);
      rdy_arr[i] = ($urandom_range(0, 9) < 8);
      junk_arr[i] = 1'b0; e_req[i] = 1'b0; e_cmp[i] = 1'b0; e_ld[i] = '0;
      e_stall[i] = 1'b0; e_ill[i] = 1'b0; e_idx[i] = -1;
    end
    a = 3;
    for (int k = 0; k < NI; k++) begin
      r = $urandom_range(0, 19);
      if (r < 6)       t = 0;
      else if (r < 14) t = 1 + (r % NUM_LD);
      else if (r < 17) t = 15;
      else if (r == 17) t = 4;
      else if (r == 18) t = 9;
      else             t = 14;
      typ_arr[k] = t;
      dep_arr[k] = NUM_LD'($urandom);
      words[k] = mk_word(4'(t), dep_arr[k]);
      avail[k] = a;
      a += $urandom_range(0, 9);
    end
    for (int ch = 0; ch < NUM_LD; ch++) last_ld[ch] = -100;
    prev = -2;
    end_cyc = 4;
    for (int k = 0; k < NI; k++) begin
      lc = (prev + 2 > avail[k]) ? prev + 2 : avail[k];
      c = lc + 1;
      while (c < NCYC - 8 && !issue_ok(k, c)) begin
        e_stall[c] = 1'b1;
        junk_arr[c] = ($urandom_range(0, 2) == 0);
        c++;
      end
      if (c >= NCYC - 8) break;
      iss = c + 1;
      junk_arr[c] = ($urandom_range(0, 2) == 0);
      junk_arr[iss] = ($urandom_range(0, 2) == 0);
      e_req[iss] = 1'b1;
      e_idx[iss] = k;
      t = typ_arr[k];
      if (t == 0) e_cmp[iss] = 1'b1;
      else if (t <= NUM_LD) begin
        e_ld[iss][t - 1] = 1'b1;
        last_ld[t - 1] = iss;
      end else if (t != 15) e_ill[iss] = 1'b1;
      prev = iss;
      end_cyc = iss + 4;
    end
  endtask

  task automatic test_reset();
    reset_dut();
    n_cmp++;
    if (inst_req !== 1'b0 || cmp_conf !== 1'b0 || ld_conf !== '0) begin
      n_bad++; $display("FAIL reset_pulses req=%b cmp=%b ld=%b want 0", inst_req, cmp_conf, ld_conf);
    end
    n_cmp++;
    if (cmp_payload !== '0 || ld_payload !== '0 || ld_sel !== 4'd0) begin
      n_bad++; $display("FAIL reset_payload ld_sel=%0d want 0, payloads nonzero or X", ld_sel);
    end
    n_cmp++;
    if (err_illegal !== 1'b0 || issue_cnt !== '0 || stall_cnt !== '0) begin
      n_bad++; $display("FAIL reset_counters err=%b issue=%0d stall=%0d want 0", err_illegal, issue_cnt, stall_cnt);
    end
  endtask

  task automatic test_compute_latency();
    logic [INST_LEN-1:0] w;
    reset_dut();
    cmp_ready = 1'b1; ld_idle = '1;
    w = mk_word(4'd0, 3'b000);
    inst = w; inst_empty = 1'b0;
    tick();
    n_cmp++;
    if (inst_req !== 1'b0 || cmp_conf !== 1'b0) begin
      n_bad++; $display("FAIL cmp_early req=%b conf=%b want 0", inst_req, cmp_conf);
    end
    tick();
    n_cmp++;
    if (inst_req !== 1'b1 || cmp_conf !== 1'b1 || ld_conf !== '0) begin
      n_bad++; $display("FAIL cmp_latency req=%b conf=%b ld=%b want 1 1 0", inst_req, cmp_conf, ld_conf);
    end
    n_cmp++;
    if (cmp_payload !== w[4 +: CMP_LEN]) begin
      n_bad++; $display("FAIL cmp_payload got %h want %h", cmp_payload, w[4 +: CMP_LEN]);
    end
    inst_empty = 1'b1;
    tick();
    n_cmp++;
    if (issue_cnt !== 32'd1 || inst_req !== 1'b0) begin
      n_bad++; $display("FAIL cmp_retire issue_cnt=%0d req=%b want 1 0", issue_cnt, inst_req);
    end
  endtask

  task automatic test_back_to_back();
    logic [INST_LEN-1:0] w1, w2;
    reset_dut();
    ld_idle = '1;
    w1 = mk_word(4'd3, 3'b000);
    w2 = mk_word(4'd3, 3'b000);
    inst = w1; inst_empty = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if (ld_conf !== 3'b100 || ld_sel !== 4'd2 || ld_payload !== w1[4 +: LD_LEN]) begin
      n_bad++; $display("FAIL ld_first conf=%b sel=%0d want 100 2", ld_conf, ld_sel);
    end
    inst = w2;
    for (int i = 3; i < 6; i++) begin
      tick();
      n_cmp++;
      if (ld_conf !== '0) begin
        n_bad++; $display("FAIL ld_spacing cyc=%0d conf=%b want 000", i, ld_conf);
      end
    end
    tick();
    n_cmp++;
    if (ld_conf !== 3'b100 || ld_payload !== w2[4 +: LD_LEN]) begin
      n_bad++; $display("FAIL ld_second conf=%b want 100", ld_conf);
    end
    inst_empty = 1'b1;
  endtask

  task automatic test_illegal();
    reset_dut();
    inst = mk_word(4'h9, 3'b000); inst_empty = 1'b0;
    repeat (2) tick();
    n_cmp++;
    if (inst_req !== 1'b1 || cmp_conf !== 1'b0 || ld_conf !== '0) begin
      n_bad++; $display("FAIL illegal_pop req=%b cmp=%b ld=%b want 1 0 0", inst_req, cmp_conf, ld_conf);
    end
    inst = mk_word(4'd4, 3'b000);
    tick();
    n_cmp++;
    if (err_illegal !== 1'b1 || issue_cnt !== 32'd1) begin
      n_bad++; $display("FAIL illegal_flag err=%b issue=%0d want 1 1", err_illegal, issue_cnt);
    end
    repeat (3) tick();
    n_cmp++;
    if (inst_req !== 1'b1 || ld_conf !== '0 || err_illegal !== 1'b1) begin
      n_bad++; $display("FAIL illegal_chan req=%b ld=%b err=%b want 1 000 1", inst_req, ld_conf, err_illegal);
    end
    inst_empty = 1'b1;
    tick();
    n_cmp++;
    if (issue_cnt !== 32'd2 || err_illegal !== 1'b1) begin
      n_bad++; $display("FAIL illegal_count issue=%0d err=%b want 2 1", issue_cnt, err_illegal);
    end
  endtask

  task automatic test_stall();
    logic [INST_LEN-1:0] w;
    reset_dut();
    cmp_ready = 1'b1; ld_idle = 3'b101;
    w = mk_word(4'd0, 3'b010);
    inst = w; inst_empty = 1'b0;
    tick();
    inst_empty = 1'b1;
    inst = mk_word(4'hF, 3'b111);
    repeat (10) tick();
    n_cmp++;
    if (stall_cnt !== 32'd10 || inst_req !== 1'b0) begin
      n_bad++; $display("FAIL stall_count stall=%0d req=%b want 10 0", stall_cnt, inst_req);
    end
    ld_idle = 3'b111;
    tick();
    n_cmp++;
    if (inst_req !== 1'b1 || cmp_conf !== 1'b1 || cmp_payload !== w[4 +: CMP_LEN]) begin
      n_bad++; $display("FAIL stall_release req=%b conf=%b want 1 1", inst_req, cmp_conf);
    end
    tick();
    n_cmp++;
    if (stall_cnt !== 32'd10) begin
      n_bad++; $display("FAIL stall_hold stall=%0d want 10", stall_cnt);
    end
  endtask

  task automatic test_reset_mid_wait();
    logic [INST_LEN-1:0] w;
    reset_dut();
    cmp_ready = 1'b0; ld_idle = '1;
    w = mk_word(4'd0, 3'b000);
    inst = w; inst_empty = 1'b0;
    repeat (3) tick();
    n_cmp++;
    if (stall_cnt !== 32'd2) begin
      n_bad++; $display("FAIL midwait_stall stall=%0d want 2", stall_cnt);
    end
    rst_n = 1'b0;
    tick();
    n_cmp++;
    if (inst_req !== 1'b0 || cmp_conf !== 1'b0 || stall_cnt !== '0 || issue_cnt !== '0) begin
      n_bad++; $display("FAIL midwait_reset req=%b conf=%b stall=%0d issue=%0d want 0", inst_req, cmp_conf, stall_cnt, issue_cnt);
    end
    rst_n = 1'b1; cmp_ready = 1'b1;
    tick();
    n_cmp++;
    if (inst_req !== 1'b0) begin
      n_bad++; $display("FAIL midwait_early req=%b want 0", inst_req);
    end
    tick();
    n_cmp++;
    if (inst_req !== 1'b1 || cmp_conf !== 1'b1 || cmp_payload !== w[4 +: CMP_LEN]) begin
      n_bad++; $display("FAIL midwait_reissue req=%b conf=%b want 1 1", inst_req, cmp_conf);
    end
    inst_empty = 1'b1;
    tick();
  endtask

  task automatic test_random();
    int end_cyc, head, iss_sum, stall_sum, k;
    bit ill_seen;
    build_schedule(end_cyc);
    reset_dut();
    head = 0; iss_sum = 0; stall_sum = 0; ill_seen = 1'b0;
    for (int c = 0; c < end_cyc; c++) begin
      ld_idle = idle_arr[c];
      cmp_ready = rdy_arr[c];
      if (head < NI && avail[head] <= c && !junk_arr[c]) begin
        inst_empty = 1'b0; inst = words[head];
      end else begin
        inst_empty = 1'b1; inst = mk_word(4'($urandom_range(0, 15)), NUM_LD'($urandom));
      end
      @(negedge clk);
      n_cmp++;
      if (inst_req !== e_req[c] || cmp_conf !== e_cmp[c] || ld_conf !== e_ld[c]) begin
        n_bad++;
        $display("FAIL rnd_issue cyc=%0d got req=%b cmp=%b ld=%b want %b %b %b",
                 c, inst_req, cmp_conf, ld_conf, e_req[c], e_cmp[c], e_ld[c]);
      end
      n_cmp++;
      if (issue_cnt !== CNT_LEN'(iss_sum) || stall_cnt !== CNT_LEN'(stall_sum) || err_illegal !== ill_seen) begin
        n_bad++;
        $display("FAIL rnd_counters cyc=%0d got issue=%0d stall=%0d err=%b want %0d %0d %b",
                 c, issue_cnt, stall_cnt, err_illegal, iss_sum, stall_sum, ill_seen);
      end
      k = e_idx[c];
      if (k >= 0 && e_cmp[c]) begin
        n_cmp++;
        if (cmp_payload !== words[k][4 +: CMP_LEN]) begin
          n_bad++; $display("FAIL rnd_cmp_payload cyc=%0d inst=%0d got %h", c, k, cmp_payload);
        end
      end
      if (k >= 0 && e_ld[c] != '0) begin
        n_cmp++;
        if (ld_payload !== words[k][4 +: LD_LEN] || ld_sel !== 4'(typ_arr[k] - 1)) begin
          n_bad++; $display("FAIL rnd_ld_payload cyc=%0d inst=%0d sel=%0d want %0d", c, k, ld_sel, typ_arr[k] - 1);
        end
      end
      if (inst_req === 1'b1) head++;
      iss_sum += int'(e_req[c]);
      stall_sum += int'(e_stall[c]);
      if (e_ill[c]) ill_seen = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_compute_latency();
    test_back_to_back();
    test_illegal();
    test_stall();
    test_reset_mid_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
